// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor. It processes two WIDTH-bit operands DIGIT
// bits per clock through a narrow adder slice, keeping the carry in a
// register between cycles. After STEPS = WIDTH/DIGIT cycles it returns the
// sum, the carry-out and the signed overflow.
//
// Optional feature macro: SERIAL_ADDER_SAT_EN
//   When this macro is defined and a completion reports overflow, sum loads
//   the signed saturation value instead of the wrapped result. cout and
//   overflow are reported unchanged.
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 2)
//   DIGIT     bits processed per cycle (WIDTH must be a multiple of DIGIT)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request; sampled only while busy = 0
//   a, b      operands; sampled on acceptance
//   cin       carry-in; sampled on acceptance, ignored when sub = 1
//   sub       0: a + b + cin, 1: a - b; sampled on acceptance
//   busy      operation in progress
//   done      one-cycle pulse when the results update
//   sum       result; held until the next completion
//   cout      carry out of the MSB (for sub = 1, 1 means no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    // Reject illegal parameter combinations at elaboration time.
    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit_range
        $error("serial_adder: DIGIT must be in 1..WIDTH");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_digit_div
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_sum;
    logic             msb_carry_in;
    logic             ov_next;

    // ------------------------------------------------------------------
    // Adder slice: the lowest DIGIT bits of both shift registers + carry.
    // ------------------------------------------------------------------
    assign digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
    assign last      = (cnt == LAST);

    // On the final step the slice holds the operand MSBs, so the carry into
    // the MSB is recovered from its sum bit: c_in = a ^ b ^ s. b_sr already
    // holds the inverted operand for subtraction, which is what the adder saw.
    assign msb_carry_in = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ digit_sum[DIGIT-1];
    assign ov_next      = msb_carry_in ^ digit_sum[DIGIT];

    // Result shift register: new digits enter at the MSB end, so after STEPS
    // shifts the first digit has reached bit 0. Only the WIDTH-DIGIT bits
    // that must survive into later steps are stored.
    if (DIGIT == WIDTH) begin : g_single_step
        assign res_next = digit_sum[DIGIT-1:0];
    end else begin : g_multi_step
        logic [WIDTH-DIGIT-1:0] res_sr;

        assign res_next = {digit_sum[DIGIT-1:0], res_sr};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_sr <= '0;
            end else if (state == RUN) begin
                res_sr <= res_next[WIDTH-1:DIGIT];
            end
        end
    end

`ifdef SERIAL_ADDER_SAT_EN
    // Positive overflow is only possible with A non-negative, negative
    // overflow only with A negative, so A's MSB selects the clamp value.
    assign final_sum = !ov_next       ? res_next :
                       a_sr[DIGIT-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                        {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign final_sum = res_next;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values, independent of process ordering.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next; no latch.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub | cin;   // subtraction forces the +1
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= digit_sum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum      <= final_sum;
                        cout     <= digit_sum[DIGIT];
                        overflow <= ov_next;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
